// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive types and constants
package uart_pkg;

  localparam int CODEWORD_W           = 7;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for an idle-high serial input
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_codeword.sv
// rtl/uart_rx_codeword.sv - UART receiver delivering one Hamming(7,4) codeword per frame
// Optional even-parity bit and parity_err output when UART_RX_PARITY_EN is defined.
module uart_rx_codeword
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = CODEWORD_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] code_out,
  output logic                 code_valid,
  input  logic                 code_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  state_e               r_state;
  state_e               w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_code_out;
  logic                 r_code_valid;
  logic                 r_load_pend;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 r_par_bad;
  logic                 w_rx_s;
  logic                 w_mid;
  logic                 w_full;
  logic                 w_stop_sample;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rx),
    .o_q (w_rx_s)
  );

  assign w_mid         = (r_cnt == MID_CNT);
  assign w_full        = (r_cnt == FULL_CNT);
  assign w_stop_sample = (r_state == STOP) && w_full;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (!w_rx_s) w_next = START;
      START: if (w_mid) w_next = w_rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (w_full && (r_bit_idx == LAST_IDX)) w_next = PARITY;
      PARITY: if (w_full) w_next = STOP;
`else
      DATA:   if (w_full && (r_bit_idx == LAST_IDX)) w_next = STOP;
`endif
      STOP:  if (w_full) w_next = w_rx_s ? IDLE : BREAK;
      BREAK: if (w_rx_s) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_code_out   <= '0;
      r_code_valid <= 1'b0;
      r_load_pend  <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_par_bad    <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || w_full) r_cnt <= '0;
      else                                r_cnt <= r_cnt + 1'b1;

      if (r_state == START) begin
        r_bit_idx <= '0;
        r_par_bad <= 1'b0;
      end
      if ((r_state == DATA) && w_full) begin
        r_shift[r_bit_idx] <= w_rx_s;
        r_bit_idx          <= r_bit_idx + 1'b1;
      end
      if ((r_state == PARITY) && w_full) r_par_bad <= (^r_shift) ^ w_rx_s;

      // The stop sample only arms the load; the accept/overrun decision uses code_ready one cycle later.
      r_load_pend <= w_stop_sample && w_rx_s && !r_par_bad;
      r_frame_err <= w_stop_sample && !w_rx_s;

      r_overrun <= 1'b0;
      if (r_load_pend) begin
        if (!r_code_valid || code_ready) begin
          r_code_out   <= r_shift;
          r_code_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_code_valid && code_ready) begin
        r_code_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_parity_err;

  always_ff @(posedge clk) begin
    if (rst) r_parity_err <= 1'b0;
    else     r_parity_err <= w_stop_sample && w_rx_s && r_par_bad;
  end

  assign parity_err = r_parity_err;
`endif

  assign code_out   = r_code_out;
  assign code_valid = r_code_valid;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_codeword.sv
// tb/tb_uart_rx_codeword.sv - directed self-checking bench for uart_rx_codeword
module tb_uart_rx_codeword;

  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       code_ready;
  logic [6:0] code_out;
  logic       code_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int total = 0;
  int bad   = 0;
  int n_valid = 0, n_ferr = 0, n_ovr = 0, n_busy = 0, n_perr = 0;
  logic [6:0] last_word = '0;

  uart_rx_codeword #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .code_out   (code_out),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (code_valid) begin
      n_valid   <= n_valid + 1;
      last_word <= code_out;
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (overrun)   n_ovr  <= n_ovr + 1;
    if (busy)      n_busy <= n_busy + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) n_perr <= n_perr + 1;
`endif
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] frame(input logic [6:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
    return {stop, ^d, d, 1'b0};
`else
    return {1'b0, stop, d, 1'b0};
`endif
  endfunction

  task automatic send(input logic [9:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      rx = bits[i];
      tick(CPB);
    end
    rx = 1'b1;
  endtask

  int v0, f0, o0, b0, p0;
  logic [9:0] fr;

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    code_ready = 1'b1;
    tick(3);
    check("rst_code_out", code_out, 7'h00);
    check("rst_code_valid", code_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick(5);

    // clean frame, consumer always ready
    v0 = n_valid; f0 = n_ferr; o0 = n_ovr;
    send(frame(7'h55, 1'b1), NBITS);
    tick(12);
    check("clean_valid_cycles", n_valid - v0, 1);
    check("clean_word", last_word, 7'h55);
    check("clean_ferr", n_ferr - f0, 0);
    check("clean_ovr", n_ovr - o0, 0);

    // backpressure then overrun
    code_ready = 1'b0;
    o0 = n_ovr;
    send(frame(7'h0F, 1'b1), NBITS);
    tick(12);
    check("bp_first_valid", code_valid, 1'b1);
    check("bp_first_word", code_out, 7'h0F);
    send(frame(7'h33, 1'b1), NBITS);
    tick(12);
    check("ovr_word_kept", code_out, 7'h0F);
    check("ovr_pulses", n_ovr - o0, 1);
    check("ovr_still_valid", code_valid, 1'b1);
    code_ready = 1'b1;
    tick(1);
    check("drain_valid_drop", code_valid, 1'b0);
    tick(5);

    // glitch rejection
    v0 = n_valid; f0 = n_ferr; b0 = n_busy;
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(20);
    check("glitch_busy_seen", (n_busy - b0) > 0, 1'b1);
    check("glitch_idle", busy, 1'b0);
    check("glitch_no_valid", n_valid - v0, 0);
    check("glitch_no_ferr", n_ferr - f0, 0);

    // framing error followed by a held-low break
    v0 = n_valid; f0 = n_ferr;
    send(frame(7'h7F, 1'b0), NBITS);
    rx = 1'b0;
    tick(40);
    check("break_busy", busy, 1'b1);
    rx = 1'b1;
    tick(12);
    check("ferr_once", n_ferr - f0, 1);
    check("ferr_no_valid", n_valid - v0, 0);
    check("break_idle", busy, 1'b0);

    // recovery frame held without a consumer
    code_ready = 1'b0;
    send(frame(7'h01, 1'b1), NBITS);
    tick(12);
    check("recover_valid", code_valid, 1'b1);
    check("recover_word", code_out, 7'h01);

    // reset in the middle of data bit 3 drops the held word
    fr = frame(7'h2A, 1'b1);
    send(fr, 4);
    rx = fr[4];
    tick(4);
    check("mid_busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    tick(1);
    check("midrst_valid", code_valid, 1'b0);
    check("midrst_code_out", code_out, 7'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ferr", frame_err, 1'b0);
    check("midrst_ovr", overrun, 1'b0);
    rst = 1'b0;
    rx = 1'b1;
    code_ready = 1'b1;
    tick(10);
    v0 = n_valid;
    send(frame(7'h2A, 1'b1), NBITS);
    tick(12);
    check("after_rst_word", last_word, 7'h2A);
    check("after_rst_valid_cycles", n_valid - v0, 1);

`ifdef UART_RX_PARITY_EN
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    send({1'b1, 1'b1, 7'h03, 1'b0}, NBITS);
    tick(12);
    check("par_bad_perr", n_perr - p0, 1);
    check("par_bad_no_valid", n_valid - v0, 0);
    check("par_bad_no_ferr", n_ferr - f0, 0);
    v0 = n_valid; p0 = n_perr;
    send({1'b1, 1'b0, 7'h03, 1'b0}, NBITS);
    tick(12);
    check("par_good_word", last_word, 7'h03);
    check("par_good_valid", n_valid - v0, 1);
    check("par_good_no_perr", n_perr - p0, 0);
`else
    p0 = n_perr;
    check("no_parity_perr", p0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
